// File: rtl/dual_issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler: opcode constants, control bus
// width, scheduler state encoding and opcode-class helpers.
package dual_issue_scheduler_pkg;

  localparam int CTRL_BUS_W = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PAIR   = 2'd1,
    ST_SINGLE = 2'd2
  } sched_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_ALUI, OP_ALUR, OP_JALR, OP_BRANCH: uses_rs1 = 1'b1;
      default:                              uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_ALUR, OP_BRANCH: uses_rs2 = 1'b1;
      default:            uses_rs2 = 1'b0;
    endcase
  endfunction

  // Opcode class only; the rd != x0 qualification is applied by the caller.
  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_ALUI, OP_ALUR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
      default:                                             writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic is_cf(input logic [6:0] op);
    case (op)
      OP_JAL, OP_JALR, OP_BRANCH: is_cf = 1'b1;
      default:                    is_cf = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_issue_hazard_check.sv
// Combinational pair hazard check: decides whether two held instructions may
// issue in the same cycle (RAW, WAW and double control-flow are blocked).
module issue_hazard_check
  import dual_issue_scheduler_pkg::*;
(
  input  logic [24:0] inst0,
  input  logic [24:0] inst1,
  input  logic        valid0,
  input  logic        valid1,
  output logic        dual_ok
);

  logic [6:0] op0_s, op1_s;
  logic [4:0] rd0_s, rd1_s, rs1_1_s, rs2_1_s;
  logic       wr0_s, wr1_s, raw_s, waw_s, cf_s;

  assign op0_s   = inst0[6:0];
  assign op1_s   = inst1[6:0];
  assign rd0_s   = inst0[11:7];
  assign rd1_s   = inst1[11:7];
  assign rs1_1_s = inst1[19:15];
  assign rs2_1_s = inst1[24:20];

  // Writes to x0 are architecturally discarded, so they never create a hazard.
  assign wr0_s = writes_rd(op0_s) & (rd0_s != 5'd0);
  assign wr1_s = writes_rd(op1_s) & (rd1_s != 5'd0);

  assign raw_s = wr0_s & ((uses_rs1(op1_s) & (rs1_1_s == rd0_s)) |
                          (uses_rs2(op1_s) & (rs2_1_s == rd0_s)));
  assign waw_s = wr0_s & wr1_s & (rd0_s == rd1_s);
  assign cf_s  = is_cf(op0_s) & is_cf(op1_s);

  assign dual_ok = valid0 & valid1 & ~raw_s & ~waw_s & ~cf_s;

endmodule

// File: rtl/dual_issue_scheduler.sv
// Decode-to-execute issue controller: holds one decoded instruction pair and
// issues it dual or split into two single issues.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int CTRL_W = CTRL_BUS_W,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              f_valid_i,
  input  logic              f_valid1_i,
  input  logic [XLEN-1:0]   f_pc_i,
  input  logic [XLEN-1:0]   f_inst0_i,
  input  logic [XLEN-1:0]   f_inst1_i,
  input  logic [CTRL_W-1:0] f_ctrl0_i,
  input  logic [CTRL_W-1:0] f_ctrl1_i,
  output logic              f_ready_o,
  output logic              i_valid0_o,
  output logic              i_valid1_o,
  output logic [XLEN-1:0]   i_pc0_o,
  output logic [XLEN-1:0]   i_pc1_o,
  output logic [XLEN-1:0]   i_inst0_o,
  output logic [XLEN-1:0]   i_inst1_o,
  output logic [CTRL_W-1:0] i_ctrl0_o,
  output logic [CTRL_W-1:0] i_ctrl1_o,
  input  logic              i_ready_i,
  output logic [CNT_W-1:0]  split_cnt_o
);

  logic              e0_v_r, e1_v_r, e0_v_s, e1_v_s;
  logic [XLEN-1:0]   e0_pc_r, e1_pc_r, e0_pc_s, e1_pc_s;
  logic [XLEN-1:0]   e0_inst_r, e1_inst_r, e0_inst_s, e1_inst_s;
  logic [CTRL_W-1:0] e0_ctrl_r, e1_ctrl_r, e0_ctrl_s, e1_ctrl_s;
  logic [CNT_W-1:0]  split_cnt_r, split_cnt_s;

  sched_state_e state_s;
  logic         dual_ok_s, fire_s, load_s;

  issue_hazard_check u_hazard (
    .inst0   (e0_inst_r[24:0]),
    .inst1   (e1_inst_r[24:0]),
    .valid0  (e0_v_r),
    .valid1  (e1_v_r),
    .dual_ok (dual_ok_s)
  );

  // The FSM state is fully encoded by the two entry valids.
  always_comb begin
    if (!e0_v_r) begin
      state_s = ST_EMPTY;
    end else if (e1_v_r) begin
      state_s = ST_PAIR;
    end else begin
      state_s = ST_SINGLE;
    end
  end

  assign fire_s    = e0_v_r & i_ready_i;
  assign f_ready_o = ~flush_i & (~e0_v_r | (i_ready_i & (~e1_v_r | dual_ok_s)));
  assign load_s    = f_valid_i & f_ready_o;

  // Next-state for both entries and the split counter.
  always_comb begin
    e0_v_s      = e0_v_r;
    e0_pc_s     = e0_pc_r;
    e0_inst_s   = e0_inst_r;
    e0_ctrl_s   = e0_ctrl_r;
    e1_v_s      = e1_v_r;
    e1_pc_s     = e1_pc_r;
    e1_inst_s   = e1_inst_r;
    e1_ctrl_s   = e1_ctrl_r;
    split_cnt_s = split_cnt_r;
    if (flush_i) begin
      e0_v_s    = 1'b0;
      e0_pc_s   = {XLEN{1'b0}};
      e0_inst_s = {XLEN{1'b0}};
      e0_ctrl_s = {CTRL_W{1'b0}};
      e1_v_s    = 1'b0;
      e1_pc_s   = {XLEN{1'b0}};
      e1_inst_s = {XLEN{1'b0}};
      e1_ctrl_s = {CTRL_W{1'b0}};
    end else if (load_s) begin
      // Reached from EMPTY, or from PAIR/SINGLE when everything retires this edge.
      e0_v_s    = 1'b1;
      e0_pc_s   = f_pc_i;
      e0_inst_s = f_inst0_i;
      e0_ctrl_s = f_ctrl0_i;
      e1_v_s    = f_valid1_i;
      e1_pc_s   = f_valid1_i ? (f_pc_i + XLEN'(3'd4)) : {XLEN{1'b0}};
      e1_inst_s = f_valid1_i ? f_inst1_i : {XLEN{1'b0}};
      e1_ctrl_s = f_valid1_i ? f_ctrl1_i : {CTRL_W{1'b0}};
    end else begin
      case (state_s)
        ST_PAIR: begin
          if (fire_s && !dual_ok_s) begin
            e0_v_s    = 1'b1;
            e0_pc_s   = e1_pc_r;
            e0_inst_s = e1_inst_r;
            e0_ctrl_s = e1_ctrl_r;
            e1_v_s    = 1'b0;
            e1_pc_s   = {XLEN{1'b0}};
            e1_inst_s = {XLEN{1'b0}};
            e1_ctrl_s = {CTRL_W{1'b0}};
            if (split_cnt_r != {CNT_W{1'b1}}) begin
              split_cnt_s = split_cnt_r + CNT_W'(1'b1);
            end else begin
              split_cnt_s = split_cnt_r;
            end
          end else if (fire_s) begin
            e0_v_s = 1'b0;
            e1_v_s = 1'b0;
          end else begin
            e0_v_s = e0_v_r;
          end
        end
        ST_SINGLE: begin
          if (fire_s) begin
            e0_v_s = 1'b0;
          end else begin
            e0_v_s = e0_v_r;
          end
        end
        ST_EMPTY: begin
          e0_v_s = 1'b0;
        end
        default: begin
          e0_v_s = 1'b0;
          e1_v_s = 1'b0;
        end
      endcase
    end
  end

  // Entry and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_v_r      <= 1'b0;
      e0_pc_r     <= {XLEN{1'b0}};
      e0_inst_r   <= {XLEN{1'b0}};
      e0_ctrl_r   <= {CTRL_W{1'b0}};
      e1_v_r      <= 1'b0;
      e1_pc_r     <= {XLEN{1'b0}};
      e1_inst_r   <= {XLEN{1'b0}};
      e1_ctrl_r   <= {CTRL_W{1'b0}};
      split_cnt_r <= {CNT_W{1'b0}};
    end else begin
      e0_v_r      <= e0_v_s;
      e0_pc_r     <= e0_pc_s;
      e0_inst_r   <= e0_inst_s;
      e0_ctrl_r   <= e0_ctrl_s;
      e1_v_r      <= e1_v_s;
      e1_pc_r     <= e1_pc_s;
      e1_inst_r   <= e1_inst_s;
      e1_ctrl_r   <= e1_ctrl_s;
      split_cnt_r <= split_cnt_s;
    end
  end

  assign i_valid0_o  = e0_v_r;
  assign i_valid1_o  = e1_v_r & dual_ok_s;
  assign i_pc0_o     = i_valid0_o ? e0_pc_r   : {XLEN{1'b0}};
  assign i_inst0_o   = i_valid0_o ? e0_inst_r : {XLEN{1'b0}};
  assign i_ctrl0_o   = i_valid0_o ? e0_ctrl_r : {CTRL_W{1'b0}};
  assign i_pc1_o     = i_valid1_o ? e1_pc_r   : {XLEN{1'b0}};
  assign i_inst1_o   = i_valid1_o ? e1_inst_r : {XLEN{1'b0}};
  assign i_ctrl1_o   = i_valid1_o ? e1_ctrl_r : {CTRL_W{1'b0}};
  assign split_cnt_o = split_cnt_r;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed self-checking bench for dual_issue_scheduler; inputs change and
// outputs are sampled on the falling clock edge.
module tb_dual_issue_scheduler;

  localparam logic [31:0] ADDI_X1_1 = 32'h0010_0093;
  localparam logic [31:0] ADDI_X2_2 = 32'h0020_0113;
  localparam logic [31:0] ADDI_X1_2 = 32'h0020_0093;
  localparam logic [31:0] ADDI_X3_5 = 32'h0050_0193;
  localparam logic [31:0] ADD_X4_33 = 32'h0031_8233;
  localparam logic [31:0] BEQ_00    = 32'h0000_0063;
  localparam logic [31:0] JAL_X1    = 32'h0000_00ef;
  localparam logic [31:0] LUI_X0    = 32'h0000_1037;
  localparam logic [31:0] ADD_X5_00 = 32'h0000_02b3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, f_valid_i, f_valid1_i, i_ready_i;
  logic [31:0] f_pc_i, f_inst0_i, f_inst1_i, f_ctrl0_i, f_ctrl1_i;
  logic        f_ready_o, i_valid0_o, i_valid1_o;
  logic [31:0] i_pc0_o, i_pc1_o, i_inst0_o, i_inst1_o, i_ctrl0_o, i_ctrl1_o;
  logic [15:0] split_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  dual_issue_scheduler dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .f_valid_i   (f_valid_i),
    .f_valid1_i  (f_valid1_i),
    .f_pc_i      (f_pc_i),
    .f_inst0_i   (f_inst0_i),
    .f_inst1_i   (f_inst1_i),
    .f_ctrl0_i   (f_ctrl0_i),
    .f_ctrl1_i   (f_ctrl1_i),
    .f_ready_o   (f_ready_o),
    .i_valid0_o  (i_valid0_o),
    .i_valid1_o  (i_valid1_o),
    .i_pc0_o     (i_pc0_o),
    .i_pc1_o     (i_pc1_o),
    .i_inst0_o   (i_inst0_o),
    .i_inst1_o   (i_inst1_o),
    .i_ctrl0_o   (i_ctrl0_o),
    .i_ctrl1_o   (i_ctrl1_o),
    .i_ready_i   (i_ready_i),
    .split_cnt_o (split_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                       input logic v1);
    f_valid_i  = 1'b1;
    f_valid1_i = v1;
    f_pc_i     = pc;
    f_inst0_i  = i0;
    f_inst1_i  = i1;
    f_ctrl0_i  = pc ^ 32'h0000_00a0;
    f_ctrl1_i  = pc ^ 32'h0000_00b0;
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; f_valid_i = 1'b0; f_valid1_i = 1'b0; i_ready_i = 1'b0;
    f_pc_i = 32'd0; f_inst0_i = 32'd0; f_inst1_i = 32'd0; f_ctrl0_i = 32'd0; f_ctrl1_i = 32'd0;
    cyc(); cyc();
    chk("rst_ready", f_ready_o, 1);
    chk("rst_v0", i_valid0_o, 0);
    chk("rst_cnt", split_cnt_o, 0);
    rst_ni = 1'b1;

    // Independent pair issues dual.
    i_ready_i = 1'b1;
    offer(32'h100, ADDI_X1_1, ADDI_X2_2, 1'b1);
    #1 chk("empty_ready", f_ready_o, 1);
    cyc();
    chk("ind_v0", i_valid0_o, 1);
    chk("ind_v1", i_valid1_o, 1);
    chk("ind_pc0", i_pc0_o, 32'h100);
    chk("ind_pc1", i_pc1_o, 32'h104);
    chk("ind_inst1", i_inst1_o, ADDI_X2_2);
    chk("ind_ctrl1", i_ctrl1_o, 32'h1b0);
    chk("ind_ready", f_ready_o, 1);
    chk("ind_cnt", split_cnt_o, 0);
    f_valid_i = 1'b0;
    cyc();
    chk("ind_drain", i_valid0_o, 0);

    // RAW pair splits.
    offer(32'h100, ADDI_X3_5, ADD_X4_33, 1'b1);
    cyc();
    f_valid_i = 1'b0;
    chk("raw_v0", i_valid0_o, 1);
    chk("raw_v1", i_valid1_o, 0);
    chk("raw_inst0", i_inst0_o, ADDI_X3_5);
    chk("raw_ready", f_ready_o, 0);
    chk("raw_pc1_zero", i_pc1_o, 0);
    cyc();
    chk("raw2_inst0", i_inst0_o, ADD_X4_33);
    chk("raw2_pc0", i_pc0_o, 32'h104);
    chk("raw2_ctrl0", i_ctrl0_o, 32'h1b0);
    chk("raw2_v1", i_valid1_o, 0);
    chk("raw2_cnt", split_cnt_o, 1);
    chk("raw2_ready", f_ready_o, 1);
    cyc();
    chk("raw_drain", i_valid0_o, 0);

    // Two control-flow instructions split; then an rd=x0 pair issues dual.
    offer(32'h300, BEQ_00, JAL_X1, 1'b1);
    cyc();
    f_valid_i = 1'b0;
    chk("cf_v1", i_valid1_o, 0);
    chk("cf_inst0", i_inst0_o, BEQ_00);
    cyc();
    chk("cf2_inst0", i_inst0_o, JAL_X1);
    chk("cf2_pc0", i_pc0_o, 32'h304);
    chk("cf2_cnt", split_cnt_o, 2);
    offer(32'h400, LUI_X0, ADD_X5_00, 1'b1);
    cyc();
    chk("x0_v0", i_valid0_o, 1);
    chk("x0_v1", i_valid1_o, 1);
    chk("x0_inst1", i_inst1_o, ADD_X5_00);

    // Backpressure: hold three cycles with a new pair waiting.
    i_ready_i = 1'b0;
    offer(32'h500, ADDI_X1_1, ADDI_X2_2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", f_ready_o, 0);
      cyc();
      chk("bp_pc0", i_pc0_o, 32'h400);
      chk("bp_v1", i_valid1_o, 1);
      chk("bp_cnt", split_cnt_o, 2);
    end
    i_ready_i = 1'b1;
    #1 chk("bp_release_ready", f_ready_o, 1);
    cyc();
    chk("bp_next_pc0", i_pc0_o, 32'h500);
    chk("bp_next_v1", i_valid1_o, 1);

    // Single-slot load, then flush while a new pair is offered.
    offer(32'h600, ADDI_X1_1, ADDI_X2_2, 1'b0);
    cyc();
    chk("single_v0", i_valid0_o, 1);
    chk("single_v1", i_valid1_o, 0);
    chk("single_pc0", i_pc0_o, 32'h600);
    i_ready_i = 1'b0;
    flush_i = 1'b1;
    offer(32'h700, ADDI_X1_1, ADDI_X2_2, 1'b1);
    #1 chk("flush_ready", f_ready_o, 0);
    cyc();
    flush_i = 1'b0;
    f_valid_i = 1'b0;
    #1;
    chk("flush_v0", i_valid0_o, 0);
    chk("flush_v1", i_valid1_o, 0);
    chk("flush_pc0", i_pc0_o, 0);
    chk("flush_ready_after", f_ready_o, 1);
    chk("flush_cnt", split_cnt_o, 2);

    // Asynchronous reset in the middle of a held pair.
    offer(32'h800, ADDI_X1_1, ADDI_X2_2, 1'b1);
    cyc();
    f_valid_i = 1'b0;
    chk("pre_rst_v0", i_valid0_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_v0", i_valid0_o, 0);
    chk("arst_v1", i_valid1_o, 0);
    chk("arst_pc0", i_pc0_o, 0);
    chk("arst_cnt", split_cnt_o, 0);
    chk("arst_ready", f_ready_o, 1);
    cyc();
    rst_ni = 1'b1;

    // WAW pair splits.
    i_ready_i = 1'b1;
    offer(32'h900, ADDI_X1_1, ADDI_X1_2, 1'b1);
    cyc();
    f_valid_i = 1'b0;
    chk("waw_v1", i_valid1_o, 0);
    chk("waw_ready", f_ready_o, 0);
    cyc();
    chk("waw_inst0", i_inst0_o, ADDI_X1_2);
    chk("waw_cnt", split_cnt_o, 1);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Decode-to-execute issue controller for the dual-issue core.
- Holds one fetched instruction pair, each slot already run through the decoder and carrying its control bus.
- Issues both slots together when safe; otherwise splits the pair, issuing slot 0 then slot 1 on consecutive accepted cycles.
- Provides the valid/ready handshake between fetch/decode and execute, plus pipeline flush.

Parameters:
- CTRL_W, 32, width of the decoder control bus (matches the shared CTRL_BUS range).
- XLEN, 32, PC and instruction width.
- CNT_W, 16, width of the split-event counter.

Ports:
- clk_i  in  1  core clock, all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all held instructions (branch redirect)
- f_valid_i  in  1  fetch pair present
- f_valid1_i  in  1  slot 1 of fetch pair is valid (qualified by f_valid_i)
- f_pc_i  in  XLEN  PC of slot 0; slot 1 PC = f_pc_i+4
- f_inst0_i, f_inst1_i  in  XLEN  raw instructions
- f_ctrl0_i, f_ctrl1_i  in  CTRL_W  decoder control outputs
- f_ready_o  out  1  scheduler accepts the pair this cycle
- i_valid0_o, i_valid1_o  out  1  issue slot valid
- i_pc0_o, i_pc1_o  out  XLEN  issued PCs
- i_inst0_o, i_inst1_o  out  XLEN  issued instructions
- i_ctrl0_o, i_ctrl1_o  out  CTRL_W  issued control buses
- i_ready_i  in  1  execute accepts all asserted issue slots
- split_cnt_o  out  CNT_W  saturating count of split pairs

Behaviour:
- Storage: two entries E0/E1, each with valid, pc, inst, ctrl. Reset and flush clear both valids, all payloads, and split_cnt_o stays 0 after reset.
- Reset values: all outputs 0, except f_ready_o = 1, because it is combinational from empty state.
- Operand decode from inst:
  - opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20].
  - rs1 used by ALUI, ALUR, JALR, BRANCH.
  - rs2 used by ALUR, BRANCH.
  - rd written by ALUI, ALUR, LUI, AUIPC, JAL, JALR with rd != 0.
  - Control-flow (CF) = JAL, JALR, BRANCH.
  - Any other opcode is treated as reading nothing and writing nothing.
- dual_ok requires E0.v, E1.v, and none of the following:
  - RAW: E0 writes rd and E1 uses rs1 == rd or rs2 == rd.
  - WAW: both write the same nonzero rd.
  - Both entries are CF.
- Issue outputs are combinational from stored state:
  - i_valid0_o = E0.v
  - i_valid1_o = E1.v & dual_ok
  - Payloads are driven from E0/E1, and zeroed when the corresponding valid is low.
- Fire = i_valid0_o & i_ready_i.
- Ready rule: f_ready_o = ~flush_i & (~E0.v | (i_ready_i & (~E1.v | dual_ok))). The entries accept a new pair only when they will be empty after this edge.
- States: EMPTY (E0.v=0), PAIR (E0.v=1, E1.v=1), SINGLE (E0.v=1, E1.v=0).
  - EMPTY + f_valid_i & f_ready_o: load E0 from slot 0 and E1 from slot 1 (E1.v = f_valid1_i). Go to PAIR, or SINGLE if no slot 1.
  - PAIR + fire + dual_ok: both retire. Load the new pair if one is offered; otherwise go to EMPTY.
  - PAIR + fire + ~dual_ok: E0 retires; E1 shifts into E0, E1.v becomes 0; go to SINGLE. split_cnt_o increments, saturating at all-ones.
  - SINGLE + fire: E0 retires. Load the new pair if one is offered; otherwise go to EMPTY.
  - No fire: hold all state; f_ready_o = 0 while occupied.
- Flush: highest priority. Next edge clears E0/E1. No capture occurs that cycle and no counter increment. Any issue completing on the flush cycle is still considered issued; the execute stage owns squashing.
- Latency: pair accepted at edge N, visible on issue ports in cycle N+1. A split pair issues its second instruction no earlier than N+2.
- Asynchronous reset mid-operation: entries cleared immediately; outputs drop to reset values without waiting for a clock.

Decomposition:
- Add to shared defs: opcode constants (already present) and macros USES_RS1/USES_RS2/WRITES_RD/IS_CF as opcode lists.
- Add to shared defs: CTRL_BUS width; no new typedefs required.
- One sub-module: issue_hazard_check. It is combinational, takes two inst words plus valids, and outputs dual_ok.

Test Plan:
- Independent pair `addi x1,x0,1` / `addi x2,x0,2` at pc 0x100, i_ready_i=1 → next cycle i_valid0_o=i_valid1_o=1, i_pc1_o=0x104, f_ready_o=1, split_cnt_o=0.
- RAW pair `addi x3,x0,5` / `add x4,x3,x3` → cycle 1: only slot 0 valid, f_ready_o=0. Cycle 2: `add` on slot 0, pc 0x104. split_cnt_o=1.
- Two branches `beq` / `jal x1` → split into two single issues. Pair `lui x0` / `add x5,x0,x0` → dual issue, since rd=x0 is ignored.
- Backpressure: pair loaded, i_ready_i=0 for 3 cycles → outputs stable, f_ready_o=0 throughout, no counter change. Then i_ready_i=1 → both retire and the next pair loads the same edge.
- flush_i during SINGLE with f_valid_i=1 → next cycle all issue valids 0, offered pair not captured, f_ready_o=1.
- rst_ni asserted mid-PAIR, asynchronously between edges → outputs immediately 0, split_cnt_o=0, f_ready_o=1.
